// File: rtl/smg_stopwatch_core_pkg.sv
// Shared types and constants for the SS.hh stopwatch feeding the 4-digit SMG driver.
// Holds the FSM encoding, BCD geometry, default dividers and the BCD increment helper.
package smg_stopwatch_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int DATA_W     = DIGIT_W * NUM_DIGITS;

    localparam int DEF_TICK_DIV    = 500000;
    localparam int DEF_SCAN_DIV    = 50000;
    localparam int DEF_DB_CYCLES   = 1000000;
    localparam int DEF_LONG_CYCLES = 100000000;

    // Ripple decimal increment over all digits; 99.99 rolls over to 00.00.
    function automatic logic [DATA_W-1:0] bcd_inc(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        logic              carry;
        r     = d;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (d[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
                    r[i*DIGIT_W +: DIGIT_W] = 4'd0;
                end else begin
                    r[i*DIGIT_W +: DIGIT_W] = d[i*DIGIT_W +: DIGIT_W] + 4'd1;
                    carry                   = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/smg_stopwatch_core_if.sv
// Button input and display-side outputs of the stopwatch core.
// master = stopwatch core, slave = whoever drives the button and consumes the digits.
interface smg_stopwatch_core_if;
    import smg_stopwatch_core_pkg::*;

    logic              ss;
    logic [DATA_W-1:0] Data;
    logic [1:0]        Bitsel;
    logic              running;

    modport master (
        input  ss,
        output Data,
        output Bitsel,
        output running
    );

    modport slave (
        output ss,
        input  Data,
        input  Bitsel,
        input  running
    );

endinterface

// File: rtl/smg_stopwatch_core_btn_debounce.sv
// Conditions the raw start/stop button: 2-FF sync, debounce, and short/long press pulses.
// A press already held when reset is released is ignored until the button is seen released.
module smg_stopwatch_core_btn_debounce #(
    parameter int DB_CYCLES   = 1000000,
    parameter int LONG_CYCLES = 100000000
) (
    input  logic CLK,
    input  logic CLR,
    input  logic i_btn,
    output logic o_short_pulse,
    output logic o_long_pulse
);

    localparam int DBW = (DB_CYCLES   > 1) ? $clog2(DB_CYCLES)   : 1;
    localparam int LW  = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 2;

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [LW-1:0]  LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0]  LONG_PRE  = LW'(LONG_CYCLES - 2);

    logic           r_sync1;
    logic           r_sync2;
    logic [1:0]     r_sync_vld;
    logic           r_armed;
    logic           r_db_lvl;
    logic [DBW-1:0] r_db_cnt;
    logic [LW-1:0]  r_hold_cnt;
    logic           r_short;
    logic           r_long;
    logic           w_fall;

    assign w_fall = r_db_lvl && !r_sync2 && (r_db_cnt == DB_LAST);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync_vld <= 2'b00;
            r_armed    <= 1'b0;
            r_db_lvl   <= 1'b0;
            r_db_cnt   <= '0;
            r_hold_cnt <= '0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_sync1    <= i_btn;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_short    <= 1'b0;
            r_long     <= 1'b0;

            // Arm only once a genuinely released button has made it through the synchronizer.
            if (!r_armed && r_sync_vld[1] && !r_sync2 && !r_db_lvl) begin
                r_armed <= 1'b1;
            end

            if (r_sync2 == r_db_lvl) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db_cnt <= '0;
                r_db_lvl <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end

            if (w_fall) begin
                r_hold_cnt <= '0;
                r_short    <= r_armed && (r_hold_cnt != LONG_LAST);
            end else if (r_db_lvl && (r_hold_cnt != LONG_LAST)) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
                if (r_hold_cnt == LONG_PRE) begin
                    r_long <= r_armed;
                end
            end
        end
    end

    assign o_short_pulse = r_short;
    assign o_long_pulse  = r_long;

endmodule

// File: rtl/smg_stopwatch_core.sv
// SS.hh stopwatch: start/stop FSM, 1/100 s divider, 4-digit BCD counter and digit scan.
// Outputs feed the SMG driver's Data/bitsel inputs directly.
module smg_stopwatch_core
    import smg_stopwatch_core_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int SCAN_DIV    = DEF_SCAN_DIV,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic                 CLK,
    input  logic                 CLR,
    smg_stopwatch_core_if.master bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic              w_short;
    logic              w_long;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_clear;
    logic              w_tick_term;
    logic              r_running;
    logic [TW-1:0]     r_tick_cnt;
    logic [DATA_W-1:0] r_data;
    logic [SW-1:0]     r_scan_cnt;
    logic [1:0]        r_bitsel;

    smg_stopwatch_core_btn_debounce #(
        .DB_CYCLES   (DB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_btn (
        .CLK           (CLK),
        .CLR           (CLR),
        .i_btn         (bus.ss),
        .o_short_pulse (w_short),
        .o_long_pulse  (w_long)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_short) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_short || w_long) w_state_nxt = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (w_short) begin
                    w_state_nxt = ST_RUN;
                end else if (w_long) begin
                    w_state_nxt = ST_IDLE;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Terminal count uses the current state, so a tick coinciding with RUN->PAUSE still lands.
    assign w_tick_term = (r_state == ST_RUN) && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_tick_cnt <= '0;
            r_data     <= '0;
        end else begin
            if (w_clear) begin
                r_tick_cnt <= '0;
            end else begin
                case (r_state)
                    ST_RUN:   r_tick_cnt <= w_tick_term ? '0 : r_tick_cnt + 1'b1;
                    ST_PAUSE: r_tick_cnt <= r_tick_cnt;
                    default:  r_tick_cnt <= '0;
                endcase
            end

            if (w_clear) begin
                r_data <= '0;
            end else if (w_tick_term) begin
                r_data <= bcd_inc(r_data);
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_scan_cnt <= '0;
            r_bitsel   <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_bitsel   <= r_bitsel + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign bus.Data    = r_data;
    assign bus.Bitsel  = r_bitsel;
    assign bus.running = r_running;

endmodule
